// File: rtl/mux_rr_feeder_4.sv
// mux_rr_feeder_4: four valid/ready producer channels are arbitrated
// round-robin into a one-entry output register. The register publishes the
// captured word and the index of its channel (sel) on a valid/ready output,
// in the form a downstream 4:1 mux stage expects.
module mux_rr_feeder_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    input  logic             out_ready
);

    // Index of the most recently granted channel. The search starts one past it.
    logic [1:0]       last_r;
    logic             load_s;
    logic             grant_any_s;
    logic [1:0]       grant_idx_s;
    logic [3:0]       grant_onehot_s;
    logic [WIDTH-1:0] grant_data_s;

    // Round-robin search starting at last+1 and wrapping through last.
    // It depends only on registered state and in_valid, never on in_data.
    always_comb begin
        load_s         = !out_valid || out_ready;
        grant_any_s    = 1'b0;
        grant_idx_s    = last_r;
        grant_onehot_s = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = last_r + 2'(k);
            if (!grant_any_s && in_valid[cand]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        if (grant_any_s) begin
            grant_onehot_s = 4'b0001 << grant_idx_s;
        end else begin
            grant_onehot_s = 4'b0000;
        end
    end

    // A channel is accepted only when the output register can take a word.
    always_comb begin
        if (load_s) begin
            in_ready = grant_onehot_s;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Data select for the winning channel. This feeds the register D input only.
    always_comb begin
        case (grant_idx_s)
            2'd0:    grant_data_s = in_data0;
            2'd1:    grant_data_s = in_data1;
            2'd2:    grant_data_s = in_data2;
            2'd3:    grant_data_s = in_data3;
            default: grant_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Output register and pointer. Capture on a grant, empty on an idle load,
    // and hold everything under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            sel       <= 2'b00;
            last_r    <= 2'd3;
        end else if (load_s) begin
            if (grant_any_s) begin
                out_valid <= 1'b1;
                out_data  <= grant_data_s;
                sel       <= grant_idx_s;
                last_r    <= grant_idx_s;
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_mux_rr_feeder_4.sv
// Testbench for mux_rr_feeder_4. Directed vectors carry hand-computed in_ready
// and out_valid values. Each expected grant pushes (sel,data) into a queue,
// and a monitor pops and compares the queue whenever the output handshake fires.
module tb_mux_rr_feeder_4;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   sel;
    logic         out_ready;

    int checks;
    int passes;
    logic [W+1:0] exp_q[$];

    mux_rr_feeder_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after a rising edge, check the
    // combinational grant and the current out_valid, and queue the expected word.
    task automatic step(input logic [3:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [W-1:0] d3, input logic ordy,
                        input logic [3:0] exp_rdy, input logic exp_valid);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data0  = d0;
        in_data1  = d1;
        in_data2  = d2;
        in_data3  = d3;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        case (exp_rdy)
            4'b0001: exp_q.push_back({2'd0, d0});
            4'b0010: exp_q.push_back({2'd1, d1});
            4'b0100: exp_q.push_back({2'd2, d2});
            4'b1000: exp_q.push_back({2'd3, d3});
            default: ;
        endcase
    endtask

    // Monitor: samples just before each rising edge and consumes one expected word
    // per output handshake.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got sel=%0d data=0x%0h, expected none", sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sel", 32'(sel), 32'(e[W+1:W]));
                    chk("out_data", 32'(out_data), 32'(e[W-1:0]));
                end
            end
        end
    end

    initial begin
        checks    = 0;
        passes    = 0;
        rst       = 1'b0;
        in_valid  = 4'b0000;
        in_data0  = '0;
        in_data1  = '0;
        in_data2  = '0;
        in_data3  = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;

        // 1. Priority after reset, then full rotation.
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0100, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0001, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b0100, 1'b1);
        step(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1, 4'b1000, 1'b1);

        // 2. Capture (2,0x05), then hold it under backpressure for five cycles.
        step(4'b0100, 8'h00, 8'h00, 8'h05, 8'h00, 1'b1, 4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1011, 8'h10, 8'h11, 8'h00, 8'h13, 1'b0, 4'b0000, 1'b1);
            chk("hold_data", 32'(out_data), 32'h05);
            chk("hold_sel", 32'(sel), 32'd2);
        end
        step(4'b1011, 8'h10, 8'h11, 8'h00, 8'h13, 1'b1, 4'b1000, 1'b1);

        // 3. Wrap to channel 0 from last=1, then skip to channels 1 and 2.
        step(4'b0010, 8'h00, 8'h21, 8'h00, 8'h00, 1'b1, 4'b0010, 1'b1);
        step(4'b0001, 8'h30, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b1);
        step(4'b0110, 8'h00, 8'h31, 8'h32, 8'h00, 1'b1, 4'b0010, 1'b1);
        step(4'b0110, 8'h00, 8'h33, 8'h34, 8'h00, 1'b1, 4'b0100, 1'b1);

        // 4. Single requester is granted back to back.
        step(4'b0100, 8'h00, 8'h00, 8'h40, 8'h00, 1'b1, 4'b0100, 1'b1);
        step(4'b0100, 8'h00, 8'h00, 8'h41, 8'h00, 1'b1, 4'b0100, 1'b1);
        step(4'b0100, 8'h00, 8'h00, 8'h42, 8'h00, 1'b1, 4'b0100, 1'b1);
        step(4'b0100, 8'h00, 8'h00, 8'h43, 8'h00, 1'b1, 4'b0100, 1'b1);

        // 5. Idle drain; the pointer stays at 2, so the next grant is channel 3.
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 4'b1000, 1'b0);

        // 6. Asynchronous reset between edges while the word is stalled.
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 8'h60, 8'h61, 8'h62, 8'h63, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 8'h60, 8'h61, 8'h62, 8'h63, 1'b1, 4'b0010, 1'b1);
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
